// File: rtl/spi_pkg.sv
// Shared SPI definitions: counter width default, half-period helper,
// controller states and CPOL/CPHA mode encodings.
package spi_pkg;

    localparam int CNT_W_DEF = 11;
    localparam int HP_W      = CNT_W_DEF + 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } brg_state_e;

    // {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Half-period in clocks: (SPPR+1) << SPR, range 1..1024.
    function automatic logic [HP_W-1:0] half_period(input logic [2:0] sppr,
                                                    input logic [2:0] spr);
        logic [HP_W-1:0] base;
        base = {{(HP_W-3){1'b0}}, sppr} + {{(HP_W-1){1'b0}}, 1'b1};
        return base << spr;
    endfunction

endpackage

// File: rtl/spi_prescaler.sv
// Shadowed divisor plus half-period counter; emits half_tick_o on the
// clock where the counter wraps from H-1 back to 0.
module spi_prescaler
    import spi_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       brg_clr_i,
    input  logic [2:0] sppr_i,
    input  logic [2:0] spr_i,
    output logic       half_tick_o
);

    brg_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         sppr_q, sppr_d;
    logic [2:0]         spr_q, spr_d;
    logic [CNT_W:0]     h_s;
    logic [CNT_W:0]     h_last_s;
    logic               wrap_s;

    assign h_s      = (CNT_W+1)'(half_period(sppr_q, spr_q));
    assign h_last_s = h_s - {{CNT_W{1'b0}}, 1'b1};
    assign wrap_s   = ({1'b0, cnt_q} == h_last_s);

    // The entry clock into RUN only starts the count, so the first wrap
    // lands H clocks after release.
    assign half_tick_o = (state_q == ST_RUN) & ~brg_clr_i & wrap_s;

    // Next-state, counter and shadow-capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sppr_d  = sppr_q;
        spr_d   = spr_q;
        if (brg_clr_i) begin
            sppr_d = sppr_i;
            spr_d  = spr_i;
        end else begin
            sppr_d = sppr_q;
            spr_d  = spr_q;
        end
        case (state_q)
            ST_CLEAR: begin
                cnt_d = {CNT_W{1'b0}};
                if (brg_clr_i) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (brg_clr_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (wrap_s) begin
                    cnt_d = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and shadow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= {CNT_W{1'b0}};
            sppr_q  <= 3'd0;
            spr_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sppr_q  <= sppr_d;
            spr_q   <= spr_d;
        end
    end

endmodule

// File: rtl/spi_baud_gen.sv
// SPI baud-rate / SCK generator: phase flip-flop, SCK and edge strobes
// built around the shadowed prescaler.
module spi_baud_gen
    import spi_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BRG_clr,
    input  logic [2:0] SPPR,
    input  logic [2:0] SPR,
    input  logic       CPOL,
    input  logic       CPHA,
    output logic       control_BaudRate,
    output logic       baud_tick,
    output logic       SCK,
    output logic       sample_stb,
    output logic       shift_stb
);

    logic half_tick_s;
    logic phase_q, phase_d;
    logic tick_q, tick_d;
    logic sck_q, sck_d;
    logic sample_q, sample_d;
    logic shift_q, shift_d;
    logic cpol_q, cpol_d;
    logic cpha_q, cpha_d;
    logic lead_s, trail_s;

    spi_prescaler #(
        .CNT_W(CNT_W)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .brg_clr_i  (BRG_clr),
        .sppr_i     (SPPR),
        .spr_i      (SPR),
        .half_tick_o(half_tick_s)
    );

    assign lead_s  = half_tick_s & ~phase_q;
    assign trail_s = half_tick_s &  phase_q;

    // Next values for phase, SCK, strobes and mode shadows.
    always_comb begin
        phase_d  = phase_q;
        tick_d   = 1'b0;
        sck_d    = sck_q;
        sample_d = 1'b0;
        shift_d  = 1'b0;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        if (BRG_clr) begin
            // Partial period is dropped; SCK follows the live CPOL pin.
            phase_d = 1'b0;
            sck_d   = CPOL;
            cpol_d  = CPOL;
            cpha_d  = CPHA;
        end else begin
            phase_d = phase_q ^ half_tick_s;
            tick_d  = lead_s;
            sck_d   = cpol_q ^ phase_d;
            case ({cpol_q, cpha_q})
                MODE0, MODE2: begin
                    sample_d = lead_s;
                    shift_d  = trail_s;
                end
                MODE1, MODE3: begin
                    sample_d = trail_s;
                    shift_d  = lead_s;
                end
                default: begin
                    sample_d = 1'b0;
                    shift_d  = 1'b0;
                end
            endcase
        end
    end

    // Output and shadow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= 1'b0;
            tick_q   <= 1'b0;
            sck_q    <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            tick_q   <= tick_d;
            sck_q    <= sck_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
        end
    end

    assign control_BaudRate = phase_q;
    assign baud_tick        = tick_q;
    assign SCK              = sck_q;
    assign sample_stb       = sample_q;
    assign shift_stb        = shift_q;

endmodule

// File: tb/tb_spi_baud_gen.sv
// Self-checking bench for spi_baud_gen: arithmetic reference model checked
// every clock, directed scenarios with literal expectations, random traffic.
module tb_spi_baud_gen;

    logic       clk;
    logic       r_rst;
    logic       r_clr;
    logic [2:0] r_sppr;
    logic [2:0] r_spr;
    logic       r_cpol;
    logic       r_cpha;
    logic       control_BaudRate;
    logic       baud_tick;
    logic       SCK;
    logic       sample_stb;
    logic       shift_stb;

    int total;
    int bad;

    // Reference model state: edges counted since entering RUN and shadows.
    int m_run, m_k, m_h, m_cpol, m_cpha;
    int e_cbr, e_tick, e_sck, e_smp, e_shf;

    spi_baud_gen dut (
        .clk             (clk),
        .rst             (r_rst),
        .BRG_clr         (r_clr),
        .SPPR            (r_sppr),
        .SPR             (r_spr),
        .CPOL            (r_cpol),
        .CPHA            (r_cpha),
        .control_BaudRate(control_BaudRate),
        .baud_tick       (baud_tick),
        .SCK             (SCK),
        .sample_stb      (sample_stb),
        .shift_stb       (shift_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Expected outputs after an edge, from the inputs seen at that edge.
    task automatic model_step();
        int ph, toggle;
        if (r_rst) begin
            m_run = 0; m_h = 1; m_cpol = 0; m_cpha = 0;
            e_cbr = 0; e_tick = 0; e_sck = 0; e_smp = 0; e_shf = 0;
        end else if (r_clr) begin
            m_run = 0;
            m_h = (int'(r_sppr) + 1) << r_spr;
            m_cpol = int'(r_cpol); m_cpha = int'(r_cpha);
            e_cbr = 0; e_tick = 0; e_sck = int'(r_cpol); e_smp = 0; e_shf = 0;
        end else if (m_run == 0) begin
            m_run = 1; m_k = 0;
            e_cbr = 0; e_tick = 0; e_sck = m_cpol; e_smp = 0; e_shf = 0;
        end else begin
            m_k++;
            toggle = ((m_k % m_h) == 0) ? 1 : 0;
            ph = (m_k / m_h) % 2;
            e_cbr = ph;
            e_sck = m_cpol ^ ph;
            e_tick = (toggle == 1 && ph == 1) ? 1 : 0;
            if (m_cpha == 1) begin
                e_smp = (toggle == 1 && ph == 0) ? 1 : 0;
                e_shf = e_tick;
            end else begin
                e_smp = e_tick;
                e_shf = (toggle == 1 && ph == 0) ? 1 : 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        chk("control_BaudRate", int'(control_BaudRate), e_cbr);
        chk("baud_tick", int'(baud_tick), e_tick);
        chk("SCK", int'(SCK), e_sck);
        chk("sample_stb", int'(sample_stb), e_smp);
        chk("shift_stb", int'(shift_stb), e_shf);
        if (sample_stb && shift_stb) begin
            chk("strobe_overlap", 1, 0);
        end
    endtask

    task automatic load(input int sppr, input int spr, input int cpol, input int cpha);
        r_clr  = 1'b1;
        r_sppr = 3'(sppr);
        r_spr  = 3'(spr);
        r_cpol = 1'(cpol);
        r_cpha = 1'(cpha);
        cycle();
        r_clr = 1'b0;
        cycle();
    endtask

    initial begin
        int first, second, n, op;
        total = 0; bad = 0;
        m_run = 0; m_k = 0; m_h = 1; m_cpol = 0; m_cpha = 0;
        r_rst = 1'b1; r_clr = 1'b0; r_sppr = 3'd0; r_spr = 3'd0;
        r_cpol = 1'b0; r_cpha = 1'b0;
        cycle();
        cycle();
        chk("reset_cbr", int'(control_BaudRate), 0);
        chk("reset_sck", int'(SCK), 0);
        chk("reset_tick", int'(baud_tick), 0);
        r_rst = 1'b0;

        // H=1, mode 0
        load(0, 0, 0, 0);
        for (int e = 1; e <= 8; e++) begin
            cycle();
            if (e == 1) begin
                chk("h1_tick_e1", int'(baud_tick), 1);
                chk("h1_sample_e1", int'(sample_stb), 1);
            end
            if (e == 2) chk("h1_shift_e2", int'(shift_stb), 1);
        end

        // H=6, CPOL=1, CPHA=1
        load(2, 1, 1, 1);
        chk("m3_idle_sck", int'(SCK), 1);
        for (int e = 1; e <= 24; e++) begin
            cycle();
            if (e == 5) chk("m3_sck_e5", int'(SCK), 1);
            if (e == 6) begin
                chk("m3_sck_e6", int'(SCK), 0);
                chk("m3_shift_e6", int'(shift_stb), 1);
            end
            if (e == 12) begin
                chk("m3_sck_e12", int'(SCK), 1);
                chk("m3_sample_e12", int'(sample_stb), 1);
            end
            if (e == 18) chk("m3_shift_e18", int'(shift_stb), 1);
        end

        // clear mid-period at cnt=3, then restart full count
        load(2, 1, 1, 1);
        cycle(); cycle(); cycle();
        r_clr = 1'b1;
        cycle();
        chk("clr_cbr", int'(control_BaudRate), 0);
        chk("clr_sck", int'(SCK), 1);
        chk("clr_strobes", int'(sample_stb) + int'(shift_stb), 0);
        r_clr = 1'b0;
        cycle();
        first = -1;
        for (int e = 1; e <= 20; e++) begin
            cycle();
            if (first < 0 && shift_stb) first = e;
        end
        chk("restart_first_edge", first, 6);

        // maximum divisor
        load(7, 7, 0, 0);
        first = -1; second = -1;
        for (int e = 1; e <= 3100; e++) begin
            cycle();
            if (baud_tick) begin
                if (first < 0) first = e;
                else if (second < 0) second = e;
            end
        end
        chk("hmax_first_tick", first, 1024);
        chk("hmax_period", second - first, 2048);

        // SPPR change while running is ignored until a clear
        load(0, 0, 0, 0);
        r_sppr = 3'd5;
        n = 0;
        for (int e = 1; e <= 10; e++) begin
            cycle();
            if (baud_tick) n++;
        end
        chk("shadow_hold_ticks", n, 5);
        r_clr = 1'b1; cycle(); r_clr = 1'b0; cycle();
        first = -1;
        for (int e = 1; e <= 12; e++) begin
            cycle();
            if (first < 0 && baud_tick) first = e;
        end
        chk("shadow_new_h", first, 6);

        // reset mid-period with clear low
        load(2, 1, 1, 0);
        cycle(); cycle();
        r_rst = 1'b1;
        cycle();
        chk("rst_mid_cbr", int'(control_BaudRate), 0);
        chk("rst_mid_sck", int'(SCK), 0);
        r_rst = 1'b0;
        cycle();
        cycle();
        chk("rst_h1_tick", int'(baud_tick), 1);

        // randomized traffic
        for (int it = 0; it < 250; it++) begin
            op = int'($urandom_range(0, 9));
            if (op == 0) begin
                r_rst = 1'b1;
                r_clr = 1'($urandom_range(0, 1));
                cycle();
                r_rst = 1'b0;
                r_clr = 1'b0;
            end else if (op <= 6) begin
                r_clr  = 1'b1;
                r_sppr = 3'($urandom_range(0, 7));
                r_spr  = 3'($urandom_range(0, 3));
                r_cpol = 1'($urandom_range(0, 1));
                r_cpha = 1'($urandom_range(0, 1));
                n = int'($urandom_range(1, 3));
                for (int j = 0; j < n; j++) cycle();
                r_clr = 1'b0;
            end else begin
                r_sppr = 3'($urandom_range(0, 7));
                r_spr  = 3'($urandom_range(0, 7));
                r_cpol = 1'($urandom_range(0, 1));
                r_cpha = 1'($urandom_range(0, 1));
            end
            n = int'($urandom_range(5, 90));
            for (int j = 0; j < n; j++) cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
